sig_verify: RTL and testbench

- Verifier counterpart of the LDGM signature generator.
- Accepts a signature as a stream of sorted nonzero bit positions and rebuilds the syndrome H·sigᵀ by XOR-accumulating H columns fetched from an external synchronous column ROM.
- Checks that syndrome against the message hash and checks the signature Hamming weight against a window, then reports accept/reject with a reason code.
- Sits between the signature source (host/FIFO) and the H-column ROM.

---
 rtl/sig_verify.sv | 151 +++++++++++++++
 tb/tb_sig_verify.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sig_verify.sv
// rtl/sig_verify.sv - LDGM signature verifier: rebuilds H*sig^T from ROM columns and checks hash and weight
module sig_verify #(
    parameter int SIG_LEN = 9800,
    parameter int IDX_W   = 14,
    parameter int SYN_W   = 178,
    parameter int HW_W    = 8,
    parameter int W_MIN   = 1,
    parameter int W_MAX   = 100
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [SYN_W-1:0] hash,
    input  logic             idx_valid,
    output logic             idx_ready,
    input  logic [IDX_W-1:0] idx,
    input  logic             idx_last,
    output logic [IDX_W-1:0] col_addr,
    output logic             col_en,
    input  logic [SYN_W-1:0] col_dout,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [1:0]       err_code,
    output logic [HW_W-1:0]  hw
);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WAIT, S_ACC, S_CHECK, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [SYN_W-1:0] r_hash, r_syn;
    logic [IDX_W-1:0] r_col_addr, r_prev;
    logic [HW_W-1:0]  r_hw;
    logic [1:0]       r_err;
    logic             r_last, r_first, r_bad, r_cur_bad, r_done, r_valid;
    logic             w_idx_ready, w_col_en, w_busy, w_idx_bad;
    logic [1:0]       w_err;
    logic [31:0]      w_idx_ext, w_hw_ext;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_idx_ready = 1'b0;
        w_col_en    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_next = S_RECV;
            end
            S_RECV: begin
                w_idx_ready = 1'b1;
                if (idx_valid) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_col_en = 1'b1;
                w_next   = S_ACC;
            end
            S_ACC:   w_next = r_last ? S_CHECK : S_RECV;
            S_CHECK: w_next = S_DONE;
            S_DONE: begin
                w_busy = 1'b0;
                if (start) w_next = S_RECV;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Indices must be strictly increasing: duplicates would cancel columns silently.
    always_comb begin
        w_idx_ext = 32'(idx);
        w_hw_ext  = 32'(r_hw);
        w_idx_bad = (w_idx_ext >= 32'(SIG_LEN)) || (!r_first && (idx <= r_prev));
        w_err     = 2'd0;
        if (r_bad)
            w_err = 2'd3;
        else if ((w_hw_ext < 32'(W_MIN)) || (w_hw_ext > 32'(W_MAX)))
            w_err = 2'd2;
        else if (r_syn != r_hash)
            w_err = 2'd1;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_hash     <= '0;
            r_syn      <= '0;
            r_col_addr <= '0;
            r_prev     <= '0;
            r_hw       <= '0;
            r_err      <= 2'd0;
            r_last     <= 1'b0;
            r_first    <= 1'b0;
            r_bad      <= 1'b0;
            r_cur_bad  <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_hash  <= hash;
                        r_syn   <= '0;
                        r_hw    <= '0;
                        r_bad   <= 1'b0;
                        r_first <= 1'b1;
                        r_done  <= 1'b0;
                        r_valid <= 1'b0;
                        r_err   <= 2'd0;
                    end
                end
                S_RECV: begin
                    if (idx_valid) begin
                        r_col_addr <= idx;
                        r_last     <= idx_last;
                        if (r_hw != {HW_W{1'b1}}) r_hw <= r_hw + HW_W'(1);
                        r_cur_bad  <= w_idx_bad;
                        if (w_idx_bad) r_bad <= 1'b1;
                        r_prev     <= idx;
                        r_first    <= 1'b0;
                    end
                end
                // A rejected index still reads the ROM; its column is dropped here.
                S_ACC: begin
                    if (!r_cur_bad) r_syn <= r_syn ^ col_dout;
                end
                S_CHECK: begin
                    r_err   <= w_err;
                    r_valid <= (w_err == 2'd0);
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign idx_ready = w_idx_ready;
    assign col_en    = w_col_en;
    assign busy      = w_busy;
    assign col_addr  = r_col_addr;
    assign done      = r_done;
    assign valid     = r_valid;
    assign err_code  = r_err;
    assign hw        = r_hw;

endmodule

// File: tb/tb_sig_verify.sv
// tb/tb_sig_verify.sv - randomized self-checking bench for sig_verify against a behavioural model
module tb_sig_verify;
    localparam int SIG_LEN = 9800;
    localparam int IDX_W   = 14;
    localparam int SYN_W   = 178;
    localparam int HW_W    = 8;

    logic             clk = 1'b0, rst_b = 1'b0, start = 1'b0;
    logic             idx_valid = 1'b0, idx_last = 1'b0;
    logic [SYN_W-1:0] hash = '0, col_dout = '0;
    logic [IDX_W-1:0] idx = '0;
    logic             idx_ready, col_en, busy, done, valid;
    logic [IDX_W-1:0] col_addr;
    logic [1:0]       err_code;
    logic [HW_W-1:0]  hw;

    int checks = 0, errors = 0;
    int q[$];

    sig_verify dut (
        .clk(clk), .rst_b(rst_b), .start(start), .hash(hash),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx), .idx_last(idx_last),
        .col_addr(col_addr), .col_en(col_en), .col_dout(col_dout),
        .busy(busy), .done(done), .valid(valid), .err_code(err_code), .hw(hw)
    );

    always #5 clk = ~clk;

    function automatic logic [SYN_W-1:0] onehot(input int a);
        logic [SYN_W-1:0] r;
        r = '0;
        r[a % SYN_W] = 1'b1;
        return r;
    endfunction

    // Column ROM: column j of H is the unit vector at row j mod 178.
    always @(posedge clk) if (col_en) col_dout <= onehot(int'(col_addr));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [SYN_W-1:0] ref_syn();
        logic [SYN_W-1:0] r;
        r = '0;
        foreach (q[i]) if (q[i] < SIG_LEN) r ^= onehot(q[i]);
        return r;
    endfunction

    function automatic int ref_hw();
        return (q.size() > 255) ? 255 : q.size();
    endfunction

    function automatic int ref_err(input logic [SYN_W-1:0] h);
        bit bad;
        int w;
        bad = 1'b0;
        foreach (q[i]) begin
            if (q[i] >= SIG_LEN) bad = 1'b1;
            if (i > 0 && q[i] <= q[i-1]) bad = 1'b1;
        end
        w = ref_hw();
        if (bad) return 3;
        if (w < 1 || w > 100) return 2;
        if (ref_syn() != h) return 1;
        return 0;
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, "_done"},     32'(done),      0);
        check({name, "_valid"},    32'(valid),     0);
        check({name, "_err"},      32'(err_code),  0);
        check({name, "_hw"},       32'(hw),        0);
        check({name, "_busy"},     32'(busy),      0);
        check({name, "_ready"},    32'(idx_ready), 0);
        check({name, "_col_en"},   32'(col_en),    0);
        check({name, "_col_addr"}, 32'(col_addr),  0);
    endtask

    task automatic run_case(input string name, input logic [SYN_W-1:0] h,
                            input bit gaps, input int abort_at);
        int  k, cyc, n, e_err;
        bit  take;
        n     = q.size();
        e_err = ref_err(h);
        @(negedge clk);
        start = 1'b1;
        hash  = h;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        hash  = ~h;
        check({name, "_busy_run"}, 32'(busy), 1);
        check({name, "_done_clr"}, 32'(done), 0);
        k = 0;
        while (!done && cyc < 6 * n + 40) begin
            if (k < n && !(gaps && $urandom_range(3) == 0)) begin
                idx_valid = 1'b1;
                idx       = IDX_W'(q[k]);
                idx_last  = (k == n - 1);
            end else begin
                idx_valid = 1'b0;
            end
            start = gaps && ($urandom_range(7) == 0);
            #1 take = idx_valid && idx_ready;
            if (abort_at >= 0 && k == abort_at && idx_ready) begin
                rst_b = 1'b0;
                #1;
                check_reset_outputs({name, "_async_rst"});
                rst_b     = 1'b1;
                idx_valid = 1'b0;
                start     = 1'b0;
                return;
            end
            @(posedge clk);
            cyc++;
            if (take) k++;
            @(negedge clk);
        end
        idx_valid = 1'b0;
        start     = 1'b0;
        check({name, "_done"},     32'(done), 1);
        check({name, "_consumed"}, 32'(k), 32'(n));
        if (!gaps) check({name, "_latency"}, 32'(cyc), 32'(3 * n + 2));
        check({name, "_err"},   32'(err_code), 32'(e_err));
        check({name, "_valid"}, 32'(valid),    32'(e_err == 0));
        check({name, "_hw"},    32'(hw),       32'(ref_hw()));
        check({name, "_busy_done"},  32'(busy),      0);
        check({name, "_ready_done"}, 32'(idx_ready), 0);
        idx_valid = 1'b1;
        idx       = '0;
        idx_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idx_valid = 1'b0;
        check({name, "_hw_hold"},  32'(hw),       32'(ref_hw()));
        check({name, "_err_hold"}, 32'(err_code), 32'(e_err));
        check({name, "_done_hold"}, 32'(done), 1);
    endtask

    initial begin
        int v, n;
        logic [SYN_W-1:0] h;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_b = 1'b1;

        q = '{0, 5};    run_case("pair",       onehot(0) ^ onehot(5), 1'b0, -1);
        q = '{0, 178};  run_case("cancel",     '0,                    1'b0, -1);
        q = '{1};       run_case("mismatch",   onehot(2),             1'b0, -1);
        q = '{3, 2};    run_case("unsorted",   onehot(3) ^ onehot(2), 1'b0, -1);
        q = '{9800};    run_case("range",      '0,                    1'b0, -1);
        q = {};
        for (int i = 0; i <= 100; i++) q.push_back(i);
        run_case("heavy", ref_syn(), 1'b0, -1);
        q = {};
        for (int i = 0; i <= 300; i++) q.push_back(i);
        run_case("saturate", ref_syn(), 1'b0, -1);
        q = {};
        for (int i = 5; i < 15; i++) q.push_back(i);
        run_case("abort", ref_syn(), 1'b0, 3);
        q = '{0};       run_case("after_rst",  onehot(0),             1'b0, -1);
        q = '{0};       run_case("b2b",        onehot(0),             1'b0, -1);

        for (int t = 0; t < 30; t++) begin
            q = {};
            n = $urandom_range(1, 110);
            v = $urandom_range(0, 200);
            for (int i = 0; i < n && v < (1 << IDX_W); i++) begin
                q.push_back(v);
                v += $urandom_range(1, 120);
            end
            if ($urandom_range(9) == 0 && q.size() > 1) q[q.size()-1] = q[q.size()-2];
            h = ref_syn();
            if ($urandom_range(1) == 0) h[$urandom_range(SYN_W - 1)] ^= 1'b1;
            run_case($sformatf("rand%0d", t), h, t[0], -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
